// File: rtl/div_pkg.sv
// Shared types and default widths for the sequential restoring divider.
// Imported by the interface, the step cell and the top.
package div_pkg;

    localparam int DIVIDEND_W_DEF = 16;
    localparam int DIVISOR_W_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/divider_16by8_seq_if.sv
// Request/result bundle of the divider.
// The master issues requests; the divider is the slave.
interface divider_16by8_seq_if
    import div_pkg::*;
#(
    parameter int DIVIDEND_W = DIVIDEND_W_DEF,
    parameter int DIVISOR_W  = DIVISOR_W_DEF
);

    logic                  start;
    logic [DIVIDEND_W-1:0] A;
    logic [DIVISOR_W-1:0]  B;
    logic                  ready;
    logic                  done;
    logic [DIVIDEND_W-1:0] quotient;
    logic [DIVISOR_W-1:0]  remainder;
    logic                  div_by_zero;

    modport master (
        output start,
        output A,
        output B,
        input  ready,
        input  done,
        input  quotient,
        input  remainder,
        input  div_by_zero
    );

    modport slave (
        input  start,
        input  A,
        input  B,
        output ready,
        output done,
        output quotient,
        output remainder,
        output div_by_zero
    );

endinterface

// File: rtl/div_step.sv
// One restoring division step: shift in a dividend bit,
// subtract the divisor when it fits.
module div_step #(
    parameter int DIVISOR_W = 8
) (
    input  logic [DIVISOR_W:0]   rem_in,
    input  logic [DIVISOR_W-1:0] divisor,
    input  logic                 bit_in,
    output logic [DIVISOR_W:0]   rem_out,
    output logic                 q_bit
);

    logic [DIVISOR_W:0] shifted;
    logic [DIVISOR_W:0] div_ext;

    always_comb begin
        shifted = {rem_in[DIVISOR_W-1:0], bit_in};
        div_ext = {1'b0, divisor};
        q_bit   = (shifted >= div_ext);
        rem_out = q_bit ? (shifted - div_ext) : shifted;
    end

endmodule

// File: rtl/divider_16by8_seq.sv
// Sequential restoring divider: one quotient bit per clock,
// results published together with the done pulse.
module divider_16by8_seq
    import div_pkg::*;
#(
    parameter int DIVIDEND_W = DIVIDEND_W_DEF,
    parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
    input logic                 clk,
    input logic                 rst,
    divider_16by8_seq_if.slave  bus
);

    localparam int CW = $clog2(DIVIDEND_W + 1);
    localparam logic [CW-1:0] LAST = CW'(DIVIDEND_W - 1);

    state_t                state;
    logic [DIVIDEND_W-1:0] a_sh;
    logic [DIVISOR_W-1:0]  b_r;
    logic [DIVISOR_W:0]    rem_r;
    logic [DIVIDEND_W-1:0] q_r;
    logic [CW-1:0]         cnt;
    logic                  zero_r;
    logic                  zwait;

    logic                  ready_r;
    logic                  done_r;
    logic [DIVIDEND_W-1:0] quot_r;
    logic [DIVISOR_W-1:0]  remo_r;
    logic                  dz_r;

    logic [DIVISOR_W:0]    step_rem;
    logic                  step_q;

    div_step #(
        .DIVISOR_W (DIVISOR_W)
    ) u_step (
        .rem_in  (rem_r),
        .divisor (b_r),
        .bit_in  (a_sh[DIVIDEND_W-1]),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            a_sh    <= '0;
            b_r     <= '0;
            rem_r   <= '0;
            q_r     <= '0;
            cnt     <= '0;
            zero_r  <= 1'b0;
            zwait   <= 1'b0;
            ready_r <= 1'b1;
            done_r  <= 1'b0;
            quot_r  <= '0;
            remo_r  <= '0;
            dz_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sh    <= bus.A;
                        b_r     <= bus.B;
                        rem_r   <= '0;
                        q_r     <= '0;
                        cnt     <= '0;
                        ready_r <= 1'b0;
                        zero_r  <= (bus.B == '0);
                        zwait   <= (bus.B == '0);
                        state   <= (bus.B == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh << 1;
                    rem_r <= step_rem;
                    q_r   <= {q_r[DIVIDEND_W-2:0], step_q};
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) state <= DONE;
                end
                DONE: begin
                    // Zero divisor spends one settle cycle here so both
                    // paths publish from the same DONE exit.
                    if (zwait) begin
                        zwait <= 1'b0;
                    end else begin
                        done_r  <= 1'b1;
                        ready_r <= 1'b1;
                        dz_r    <= zero_r;
                        quot_r  <= zero_r ? '1 : q_r;
                        remo_r  <= zero_r ? '0 : rem_r[DIVISOR_W-1:0];
                        state   <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ready       = ready_r;
    assign bus.done        = done_r;
    assign bus.quotient    = quot_r;
    assign bus.remainder   = remo_r;
    assign bus.div_by_zero = dz_r;

endmodule

// File: doc/divider_16by8_seq.md
DIVIDER_16BY8_SEQ -- requirements
Module: divider_16by8_seq

Interface
REQ-001 The block SHALL have the parameter DIVIDEND_W, default 16, which sets the dividend and quotient width.
REQ-002 The block SHALL have the parameter DIVISOR_W, default 8, which sets the divisor and remainder width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 start  input  1  SHALL request a division; it is sampled only when ready=1.
REQ-006 A  input  DIVIDEND_W  SHALL carry the dividend, captured when start is accepted.
REQ-007 B  input  DIVISOR_W  SHALL carry the divisor, captured when start is accepted.
REQ-008 ready  output  1  SHALL be high in IDLE only.
REQ-009 done  output  1  SHALL pulse high for exactly one cycle when a result is valid.
REQ-010 quotient  output  DIVIDEND_W  SHALL carry the result quotient.
REQ-011 remainder  output  DIVISOR_W  SHALL carry the result remainder.
REQ-012 div_by_zero  output  1  SHALL flag that the last accepted request had B=0.

Function
REQ-013 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-014 IDLE with start=1 SHALL capture A and B, clear the iteration counter and the partial remainder, and go to RUN (B≠0) or DONE (B=0).
REQ-015 IDLE with start=0 SHALL remain in IDLE with outputs held.
REQ-016 RUN SHALL perform one restoring step per cycle: shift the (DIVISOR_W+1)-bit partial remainder left, inserting the dividend MSB; if the result is ≥B, subtract B and shift in quotient bit 1, else shift in 0.
REQ-017 RUN SHALL last exactly DIVIDEND_W cycles (16), then enter DONE.
REQ-018 DONE SHALL assert done for one cycle and return to IDLE unconditionally.
REQ-019 For a start accepted at edge N, done SHALL be high in the cycle after edge N+17 when B≠0, and after edge N+2 when B=0.
REQ-020 In the divide-by-zero case, quotient SHALL be all ones, remainder SHALL be 0 and div_by_zero=1.
REQ-021 For B≠0, the results SHALL satisfy A = quotient*B + remainder with remainder < B, and div_by_zero SHALL be 0.
REQ-022 quotient, remainder and div_by_zero SHALL hold their values until the next accepted start updates them in DONE; they may show intermediate values during RUN.
REQ-023 Changes on start, A or B while ready=0 SHALL be ignored and SHALL NOT affect the operation in flight.
REQ-024 start held high continuously SHALL begin a new operation in the IDLE cycle following each DONE.

Reset
REQ-025 While rst=1, the state SHALL be IDLE, ready=1, done=0, quotient=0, remainder=0, div_by_zero=0, and the counter and internal registers SHALL be 0.
REQ-026 Reset asserted mid-RUN SHALL abort the operation immediately, with no done pulse.
REQ-027 The first start accepted after reset release SHALL be honoured on the first rising edge with rst=0.

Structure
REQ-028 The shared package div_pkg SHALL hold the state typedef (IDLE/RUN/DONE) and the default width constants.
REQ-029 One combinational sub-module, div_step, SHALL implement a single restoring step (partial remainder in, divisor, next bit → partial remainder out, quotient bit).
REQ-030 The RTL SHALL be synthesizable, with no division operator.

Verification
REQ-031 A=11270, B=115, start pulse → done 17 cycles later, quotient=98, remainder=0, div_by_zero=0.
REQ-032 A=16837, B=99 → quotient=170, remainder=7; A=65535, B=1 → quotient=65535, remainder=0.
REQ-033 A=9618, B=0 → done 2 cycles after acceptance, quotient=16'hFFFF, remainder=0, div_by_zero=1.
REQ-034 Start with A=9618, B=42; change A/B and pulse start during RUN → result quotient=229, remainder=0, and no second done pulse.
REQ-035 Assert rst at RUN cycle 8 → ready=1 and all outputs 0 immediately, with no done pulse; a following request A=100, B=7 → quotient=14, remainder=2.
REQ-036 A randomized sweep of 1000 pairs, with B including 1 and 255, SHALL satisfy A = q*B + r and r < B at every done pulse.
